// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker with lock detection and saturating error count
module prbs_checker #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter int               LOCK_CNT    = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bit_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        bit_err,
  output logic [15:0] err_count
);
  localparam int FW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [FW-1:0]    r_fill_cnt;
  logic [7:0]       r_match_cnt;
  logic [15:0]      r_win_cnt;
  logic [15:0]      r_win_err;
  logic             w_mis;
  logic             w_lk_mis;
  logic [7:0]       w_match_n;
  logic [15:0]      w_win_cnt_n;
  logic [15:0]      w_win_err_n;
  logic [15:0]      w_err_base;
  assign w_mis       = bit_in ^ (^(r_sr & TAPS));
  assign w_lk_mis    = enable && r_state == LOCKED && w_mis;
  assign w_match_n   = r_match_cnt + 8'd1;
  assign w_win_cnt_n = r_win_cnt + 16'd1;
  assign w_win_err_n = r_win_err + 16'(w_mis);
  // clear takes effect first so a coincident mismatch still counts as one
  assign w_err_base  = clr_cnt ? 16'd0 : err_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      locked      <= 1'b0;
      bit_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      bit_err   <= w_lk_mis;
      err_count <= w_err_base + 16'(w_lk_mis && w_err_base != 16'hFFFF);
      if (enable) begin
        r_sr <= {r_sr[WIDTH-2:0], bit_in};
        case (r_state)
          FILL: begin
            r_fill_cnt <= r_fill_cnt + FW'(1);
            if (r_fill_cnt == FW'(WIDTH - 1)) r_state <= SEARCH;
          end
          SEARCH: begin
            // an all-zero register predicts zero forever, so it never earns credit
            r_match_cnt <= (w_mis || r_sr == '0) ? 8'd0 : w_match_n;
            if (!w_mis && r_sr != '0 && w_match_n == 8'(LOCK_CNT)) begin
              r_state   <= LOCKED;
              locked    <= 1'b1;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end
          end
          default: begin
            if (w_win_err_n >= 16'(LOSS_THRESH)) begin
              r_state     <= SEARCH;
              locked      <= 1'b0;
              r_match_cnt <= '0;
            end else if (w_win_cnt_n == 16'(WINDOW)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= w_win_cnt_n;
              r_win_err <= w_win_err_n;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed test plan plus random stream checked against a history-based model
module tb_prbs_checker;
  logic        clk = 0, rst = 1, enable = 0, bit_in = 0, clr_cnt = 0;
  logic        locked, bit_err;
  logic [15:0] err_count;
  int          n_assert = 0, n_fail = 0;
  logic [7:0]  g;
  bit          hist[$];
  int          m_filled, m_run, m_win_bits, m_win_errs, m_errs;
  bit          m_locked, m_bit_err;

  prbs_checker dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .clr_cnt(clr_cnt),
    .locked(locked), .bit_err(bit_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // next bit = parity of the received bits 4, 5, 6 and 8 positions back (taps 8'hB8)
  function automatic bit predict();
    int d[4] = '{4, 5, 6, 8};
    bit p = 0;
    foreach (d[i]) if (hist.size() >= d[i]) p ^= hist[hist.size() - d[i]];
    return p;
  endfunction

  function automatic bit all_zero();
    foreach (hist[i]) if (hist[i]) return 0;
    return 1;
  endfunction

  task automatic step(input bit en, input bit b, input bit clr, input bit r);
    bit mis = 0, lm = 0;
    enable = en; bit_in = b; clr_cnt = clr; rst = r;
    @(posedge clk); #1;
    if (r) begin
      hist.delete();
      m_filled = 0; m_run = 0; m_win_bits = 0; m_win_errs = 0; m_errs = 0;
      m_locked = 0; m_bit_err = 0;
    end else begin
      if (en) begin
        mis = b != predict();
        if (m_filled < 8) m_filled++;
        else if (!m_locked) begin
          m_run = (mis || all_zero()) ? 0 : m_run + 1;
          if (m_run == 16) begin m_locked = 1; m_win_bits = 0; m_win_errs = 0; end
        end else begin
          lm = mis;
          m_win_bits++;
          m_win_errs += int'(mis);
          if (m_win_errs >= 8) begin m_locked = 0; m_run = 0; end
          else if (m_win_bits == 64) begin m_win_bits = 0; m_win_errs = 0; end
        end
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
      end
      m_bit_err = lm;
      if (clr) m_errs = 0;
      if (lm && m_errs < 65535) m_errs++;
    end
    chk("locked", int'(locked), int'(m_locked));
    chk("bit_err", int'(bit_err), int'(m_bit_err));
    chk("err_count", int'(err_count), m_errs);
  endtask

  // drive one generator bit (optionally inverted); generator advances only on valid bits
  task automatic gbit(input bit en, input bit flip, input bit clr);
    bit o = g[0];
    if (en) g = {g[6:0], ^(g & 8'hB8)};
    step(en, o ^ flip, clr, 0);
  endtask

  task automatic sync_window();
    int k = 0;
    while (m_win_bits != 1 && k < 200) begin gbit(1, 0, 0); k++; end
    chk("win_sync", int'(k < 200), 1);
  endtask

  initial begin
    int t, pulses, fell, relock;
    bit stay;
    g = 8'h55;
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_bit_err", int'(bit_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    t = 0;
    while (!locked && t < 60) begin gbit(1, 0, 0); t++; end
    chk("lock_latency", t, 24);
    for (int i = t; i < 200; i++) gbit(1, 0, 0);
    chk("clean_errs", int'(err_count), 0);
    sync_window();
    pulses = 0; stay = 1;
    for (int i = 0; i < 20; i++) begin
      gbit(1, i == 0, 0);
      pulses += int'(bit_err);
      stay &= locked;
    end
    chk("single_pulses", pulses, 5);
    chk("single_errs", int'(err_count), 5);
    chk("single_stay", int'(stay), 1);
    gbit(1, 0, 1);
    chk("clr", int'(err_count), 0);
    sync_window();
    pulses = 0; fell = -1; relock = -1;
    for (int i = 0; i < 60; i++) begin
      gbit(1, i == 0 || i == 10, 0);
      pulses += int'(bit_err);
      if (!locked && fell < 0) begin
        fell = i;
        chk("loss_pulses", pulses, 8);
        chk("loss_errs", int'(err_count), 8);
      end
      if (locked && fell >= 0 && relock < 0) relock = i;
    end
    chk("fall_idx", fell, 15);
    chk("relock_bits", relock - fell, 19);
    chk("loss_final_errs", int'(err_count), 8);
    gbit(1, 0, 1);
    stay = 1;
    for (int i = 0; i < 100; i++) begin
      gbit(1, i == 0 || i == 70, 0);
      stay &= locked;
    end
    chk("window_errs", int'(err_count), 10);
    chk("window_stay", int'(stay), 1);
    sync_window();
    gbit(1, 1, 1);
    chk("clr_with_mis", int'(err_count), 1);
    for (int i = 0; i < 19; i++) gbit(1, 0, 0);
    chk("clr_mis_tail", int'(err_count), 5);
    step(1, 1, 1, 1);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_bit_err", int'(bit_err), 0);
    chk("mid_rst_err_count", int'(err_count), 0);
    t = 0;
    while (!locked && t < 60) begin gbit(1, 0, 0); t++; end
    chk("relock_after_rst", t, 24);
    step(0, 0, 0, 1);
    stay = 0;
    for (int i = 0; i < 100; i++) begin step(1, 0, 0, 0); stay |= locked; end
    chk("zero_never_locks", int'(stay), 0);
    chk("zero_errs", int'(err_count), 0);
    step(0, 0, 0, 1);
    g = 8'h55;
    t = 0;
    while (!locked && t < 120) begin gbit(t % 2 == 1, 0, 0); t++; end
    chk("toggle_cycles", t, 48);
    g = 8'($urandom_range(1, 255));
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) step(1, 1, 1, 1);
      else gbit($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that sits directly downstream of the `lfsr` generator and consumes one bit of its output stream (normally `lfsr_out[0]`) per enabled cycle. It self-synchronises to the incoming sequence using the same feedback polynomial, declares lock after a run of correct predictions, and then counts bit errors. It drops lock when too many errors arrive inside a window. It is the receive-side counterpart used in link loopback and BIST checks.

## Interface
- `WIDTH`, 8: shift-register length; must equal the generator's `WIDTH`.
- `TAPS`, 8'hB8: feedback mask. The predicted bit is the XOR of `sr & TAPS`.
- `LOCK_CNT`, 16: consecutive correct predictions required to lock (1..255).
- `WINDOW`, 64: window length for loss-of-lock, in valid bits (2..65535).
- `LOSS_THRESH`, 8: mismatches within one window that force loss of lock (1..WINDOW).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: the bit on `bit_in` is valid this cycle.
- `bit_in`, in, 1: received PRBS bit.
- `clr_cnt`, in, 1: synchronous clear of `err_count`; does not affect lock state.
- `locked`, out, 1: checker is in the LOCKED state.
- `bit_err`, out, 1: one-cycle pulse for each mismatch detected while LOCKED.
- `err_count`, out, 16: saturating count of LOCKED mismatches.

## Operation
- Internal `sr[WIDTH-1:0]`.
  - On every valid bit: `sr <= {sr[WIDTH-2:0], bit_in}`. The received bit is always shifted in, never the predicted one (self-synchronous).
  - Predicted bit: `p = ^(sr & TAPS)`, using `sr` before the shift.
  - Mismatch: `bit_in != p`.
- FILL state (after reset):
  - No comparisons.
  - `fill_cnt` counts valid bits; after `WIDTH` valid bits, go to SEARCH.
- SEARCH state:
  - Each valid bit is compared.
  - A match with `sr != 0` increments `match_cnt`.
  - A mismatch, or a match with `sr == 0` (zero-lockup guard), clears `match_cnt` to 0.
  - When the increment makes `match_cnt == LOCK_CNT`, go to LOCKED and clear `win_cnt` and `win_err`.
- LOCKED state:
  - Each valid bit increments `win_cnt`.
  - Each mismatch pulses `bit_err`, increments `err_count` (saturating at 16'hFFFF), and increments `win_err`.
  - If the updated `win_err >= LOSS_THRESH`, go to SEARCH with `match_cnt = 0`. No refill: `sr` stays valid.
  - Otherwise, on the valid bit that makes `win_cnt == WINDOW`, clear `win_cnt` and `win_err`. The threshold check on that bit happens before the window clear.
- Lock-state counters are never incremented by SEARCH mismatches.
- `enable = 0`: all state holds; `bit_err = 0`.
- `clr_cnt` with a simultaneous LOCKED mismatch: `err_count` becomes 1. `clr_cnt` otherwise sets `err_count` to 0.

## Timing
- Reset values: `locked = 0`, `bit_err = 0`, `err_count = 0`, `sr = 0`, state FILL, all internal counters 0.
- Reset asserted mid-operation returns the block to FILL on the next edge, regardless of `enable` or `clr_cnt`.
- Outputs are registered and reflect the bit sampled at the previous rising edge.
  - `locked` rises in the cycle after the edge that samples the `LOCK_CNT`-th consecutive match.
  - `locked` falls in the cycle after the edge whose mismatch reaches `LOSS_THRESH`.
  - `bit_err` and the `err_count` increment appear in the cycle after the offending bit.
- Minimum time to lock from reset: `WIDTH + LOCK_CNT` valid bits (24 with defaults).
- With defaults (4 taps), a single inverted bit while LOCKED causes exactly 5 mismatches:
  - the bit itself;
  - then each later prediction that uses it (4 more), within the next `WIDTH` valid bits.

## Test plan
- Lock: reset, then `lfsr` seeded with 8'h55 feeding `lfsr_out[0]` with `enable = 1` continuously. Required: `locked` rises exactly 24 valid bits after reset release, `err_count = 0` after 200 bits.
- Single error: once locked, invert one bit. Required: exactly 5 `bit_err` pulses, `err_count = 5`, `locked` stays 1.
- Loss of lock: invert two bits 10 positions apart within one window. Required: `locked` falls on the 8th mismatch, `err_count = 8`. `locked` relocks after 16 further clean bits.
- Window clear: invert one bit, then one more bit 70 valid bits later. Required: `err_count = 10`, `locked` never drops.
- Zero stream and gaps:
  - All-zero `bit_in` for 100 bits: `locked` stays 0.
  - Clean stream with `enable` toggled 1/0 every cycle: lock after 24 valid bits, 48 cycles.
- Clear and reset:
  - `clr_cnt` pulsed on the same cycle as a mismatch: `err_count = 1`.
  - `rst` pulsed while locked: all outputs 0 on the next cycle, relock after 24 valid bits.
